// File: rtl/lcd_cmd_scheduler_if.sv
// Handshake bundle between the two LCD requesters, the scheduler and the instruction FSM.
// The master side is the client/instruction-FSM side; the slave side is the scheduler.
interface lcd_cmd_scheduler_if;
  logic       req0;
  logic [9:0] data0;
  logic       ack0;
  logic       req1;
  logic [9:0] data1;
  logic       ack1;
  logic [9:0] instr_data;
  logic       instr_en;
  logic       instr_done;
  logic       busy;

  modport master (
    output req0, data0, req1, data1, instr_done,
    input  ack0, ack1, instr_data, instr_en, busy
  );

  modport slave (
    input  req0, data0, req1, data1, instr_done,
    output ack0, ack1, instr_data, instr_en, busy
  );
endinterface

// File: rtl/lcd_cmd_scheduler.sv
// Round-robin arbiter that feeds one LCD instruction FSM from a command and a character
// client, then holds off new grants for the HD44780 execution time of the issued word.
module lcd_cmd_scheduler #(
  parameter int unsigned SHORT_WAIT = 1999,
  parameter int unsigned LONG_WAIT  = 81999,
  parameter int unsigned CNT_W      = 17
) (
  input  logic               clk_i,
  input  logic               rst_i,
  lcd_cmd_scheduler_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StSend, StDelay} state_e;

  localparam logic [CNT_W-1:0] ShortWaitC = CNT_W'(SHORT_WAIT);
  localparam logic [CNT_W-1:0] LongWaitC  = CNT_W'(LONG_WAIT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       data_q, data_d;
  logic             long_q, long_d;
  logic             last_q, last_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             grant1;
  logic [9:0]       grant_word;
  logic [CNT_W-1:0] wait_sel;

  // Clear Display (0x000/0x001) and Return Home (0x002/0x003) need the long execution time.
  function automatic logic is_long_word(input logic [9:0] w);
    return (w[9:8] == 2'b00) && ((w[7:1] == 7'd0) || (w[7:1] == 7'd1));
  endfunction

  assign wait_sel = long_q ? LongWaitC : ShortWaitC;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    long_d     = long_q;
    last_d     = last_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    // On a tie, requester 1 wins only if requester 0 was granted last.
    grant1     = bus_io.req1 && (!bus_io.req0 || !last_q);
    grant_word = grant1 ? bus_io.data1 : bus_io.data0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.req0 || bus_io.req1) begin
          data_d  = grant_word;
          long_d  = is_long_word(grant_word);
          last_d  = grant1;
          ack0_d  = !grant1;
          ack1_d  = grant1;
          cnt_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (bus_io.instr_done) begin
          cnt_d   = '0;
          state_d = StDelay;
        end
      end
      StDelay: begin
        if (cnt_q == wait_sel) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      long_q  <= 1'b0;
      last_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      long_q  <= long_d;
      last_q  <= last_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  assign bus_io.ack0       = ack0_q;
  assign bus_io.ack1       = ack1_q;
  assign bus_io.instr_data = data_q;
  assign bus_io.instr_en   = (state_q == StSend) && !bus_io.instr_done;
  assign bus_io.busy       = (state_q != StIdle);

endmodule
